// File: rtl/mult_share_arb.sv
// Round-robin arbiter/sequencer that shares one W x W sequential multiplier core among NREQ requesters.
// Optional WAIT watchdog: define MULT_SHARE_ARB_TIMEOUT_EN to bound WAIT to TIMEOUT cycles.
module mult_share_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_product,
    output logic              rsp_err,
    output logic              mul_rst,
    output logic              mul_start,
    output logic [W-1:0]      mul_multiplier,
    output logic [W-1:0]      mul_multiplicand,
    input  logic [2*W-1:0]    mul_product,
    input  logic              mul_done
);

    localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= 8) && (TIMEOUT >= 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     rr_ptr_q;
    logic [PW-1:0]     gidx_q;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [2*W-1:0]    rsp_product_q;
    logic              rsp_err_q;
    logic              mul_rst_q;
    logic              mul_start_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     cnt_q;
`endif

    logic              arb_hit_d;
    logic [PW-1:0]     arb_idx_d;
    logic [PW:0]       cand_s;
    logic [NREQ-1:0]   arb_oh_d;
    logic [W-1:0]      a_sel_d;
    logic [W-1:0]      b_sel_d;

    // Round-robin search: first requesting index at or after rr_ptr_q, wrapping past NREQ-1.
    always_comb begin
        arb_hit_d = 1'b0;
        arb_idx_d = '0;
        cand_s    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s    = {1'b0, rr_ptr_q} + (PW+1)'(k);
            cand_s    = (cand_s >= (PW+1)'(NREQ)) ? (cand_s - (PW+1)'(NREQ)) : cand_s;
            arb_idx_d = (!arb_hit_d && req[cand_s[PW-1:0]]) ? cand_s[PW-1:0] : arb_idx_d;
            arb_hit_d = arb_hit_d | req[cand_s[PW-1:0]];
        end
    end

    // Winner decode: one-hot grant vector and the winner's operand slices.
    always_comb begin
        arb_oh_d = NREQ'(1'b1) << arb_idx_d;
        a_sel_d  = '0;
        b_sel_d  = '0;
        for (int k = 0; k < NREQ; k++) begin
            a_sel_d = (arb_idx_d == PW'(k)) ? a_in[k*W +: W] : a_sel_d;
            b_sel_d = (arb_idx_d == PW'(k)) ? b_in[k*W +: W] : b_sel_d;
        end
    end

    // Sequencer FSM; every output is a register updated on the transition into the state that shows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            gidx_q        <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
            mul_rst_q     <= 1'b1;
            mul_start_q   <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // An out-of-range configuration never grants.
                    if (arb_hit_d && CFG_OK) begin
                        gnt_q     <= arb_oh_d;
                        gidx_q    <= arb_idx_d;
                        a_q       <= a_sel_d;
                        b_q       <= b_sel_d;
                        mul_rst_q <= 1'b1;
                        state_q   <= ST_CLR;
                    end else begin
                        mul_rst_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    mul_rst_q   <= 1'b0;
                    mul_start_q <= 1'b1;
                    state_q     <= ST_LOAD;
                end
                ST_LOAD: begin
                    mul_start_q <= 1'b0;
                    state_q     <= ST_WAIT;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        rsp_product_q <= mul_product;
                        rsp_err_q     <= 1'b0;
                        rsp_valid_q   <= gnt_q;
                        mul_rst_q     <= 1'b1;
                        state_q       <= ST_DONE;
                    end
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_product_q <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_valid_q   <= gnt_q;
                        mul_rst_q     <= 1'b1;
                        state_q       <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= ST_WAIT;
                    end
`else
                    else begin
                        state_q <= ST_WAIT;
                    end
`endif
                end
                ST_DONE: begin
                    rsp_valid_q <= '0;
                    rsp_err_q   <= 1'b0;
                    gnt_q       <= '0;
                    mul_rst_q   <= 1'b1;
                    rr_ptr_q    <= (gidx_q == PW'(NREQ - 1)) ? '0 : (gidx_q + PW'(1));
                    state_q     <= ST_IDLE;
                end
                default: begin
                    gnt_q       <= '0;
                    rsp_valid_q <= '0;
                    rsp_err_q   <= 1'b0;
                    mul_rst_q   <= 1'b1;
                    mul_start_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt              = gnt_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_product      = rsp_product_q;
    assign rsp_err          = rsp_err_q;
    assign mul_rst          = mul_rst_q;
    assign mul_start        = mul_start_q;
    assign mul_multiplier   = a_q;
    assign mul_multiplicand = b_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed self-checking bench for mult_share_arb with a behavioural multiplier core of adjustable latency.
module tb_mult_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_product;
    logic              rsp_err;
    logic              mul_rst;
    logic              mul_start;
    logic [W-1:0]      mul_multiplier;
    logic [W-1:0]      mul_multiplicand;
    logic [2*W-1:0]    mul_product;
    logic              mul_done;

    logic              core_done;
    logic              done_spur;
    logic              core_busy;
    logic [7:0]        core_cnt;
    logic [2*W-1:0]    core_acc;
    logic [7:0]        core_lat;
    logic              core_hang;

    int errors;
    int checks;

    mult_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(64)) dut (
        .clk              (clk),
        .reset            (rst_n),
        .req              (req),
        .a_in             (a_in),
        .b_in             (b_in),
        .gnt              (gnt),
        .rsp_valid        (rsp_valid),
        .rsp_product      (rsp_product),
        .rsp_err          (rsp_err),
        .mul_rst          (mul_rst),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_done         (mul_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mul_done = core_done | done_spur;

    // Stub core: mul_rst clears it, mul_start captures operands, done rises core_lat+1 cycles later and holds.
    always @(posedge clk) begin
        if (mul_rst) begin
            core_busy   <= 1'b0;
            core_done   <= 1'b0;
            core_cnt    <= 8'd0;
            mul_product <= 16'd0;
        end else if (mul_start) begin
            core_busy <= 1'b1;
            core_done <= 1'b0;
            core_cnt  <= core_lat;
            core_acc  <= 16'(mul_multiplier) * 16'(mul_multiplicand);
        end else if (core_busy && !core_hang) begin
            if (core_cnt == 8'd0) begin
                core_done   <= 1'b1;
                mul_product <= core_acc;
                core_busy   <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 8'd1;
            end
        end
    end

    task automatic wait_rsp(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_product !== 16'd0) begin errors++; $display("FAIL reset_product: got %0d want 0", rsp_product); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        checks++; if (mul_rst !== 1'b1) begin errors++; $display("FAIL reset_mul_rst: got %b want 1", mul_rst); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
        checks++; if ({mul_multiplier, mul_multiplicand} !== 16'd0) begin errors++; $display("FAIL reset_operands: got %h want 0000", {mul_multiplier, mul_multiplicand}); end
    endtask

    task automatic test_single();
        bit seen;
        core_lat = 8'd2;
        a_in[7:0] = 8'd13;
        b_in[7:0] = 8'd11;
        req = 4'b0001;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_c1: got %b want 0001", gnt); end
        checks++; if (mul_rst !== 1'b1 || mul_start !== 1'b0) begin errors++; $display("FAIL single_clr_c1: got rst=%b start=%b want rst=1 start=0", mul_rst, mul_start); end
        @(negedge clk);
        checks++; if (mul_start !== 1'b1 || mul_rst !== 1'b0) begin errors++; $display("FAIL single_load_c2: got rst=%b start=%b want rst=0 start=1", mul_rst, mul_start); end
        checks++; if (mul_multiplier !== 8'd13 || mul_multiplicand !== 8'd11) begin errors++; $display("FAIL single_operands: got %0d*%0d want 13*11", mul_multiplier, mul_multiplicand); end
        @(negedge clk);
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL single_wait_c3: got start=%b want 0", mul_start); end
        wait_rsp(seen);
        checks++; if (!seen) begin errors++; $display("FAIL single_timeout: got no rsp_valid want one"); end
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
        checks++; if (rsp_product !== 16'd143) begin errors++; $display("FAIL single_product: got %0d want 143", rsp_product); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", rsp_err); end
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_done: got %b want 0001", gnt); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_pulse_len: got %b want 0000", rsp_valid); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_clear: got %b want 0000", gnt); end
    endtask

    task automatic test_corners();
        bit seen;
        int          idx_t [3];
        logic [7:0]  a_t   [3];
        logic [7:0]  b_t   [3];
        logic [15:0] p_t   [3];
        logic [3:0]  oh_t  [3];
        idx_t = '{1, 2, 3};
        a_t   = '{8'd255, 8'd0, 8'd1};
        b_t   = '{8'd255, 8'd200, 8'd255};
        p_t   = '{16'd65025, 16'd0, 16'd255};
        oh_t  = '{4'b0010, 4'b0100, 4'b1000};
        core_lat = 8'd5;
        for (int n = 0; n < 3; n++) begin
            a_in[idx_t[n]*W +: W] = a_t[n];
            b_in[idx_t[n]*W +: W] = b_t[n];
            req = oh_t[n];
            wait_rsp(seen);
            checks++; if (!seen || rsp_valid !== oh_t[n]) begin errors++; $display("FAIL corner_valid_%0d: got %b want %b", n, rsp_valid, oh_t[n]); end
            checks++; if (rsp_product !== p_t[n]) begin errors++; $display("FAIL corner_product_%0d: got %0d want %0d", n, rsp_product, p_t[n]); end
            req = 4'b0000;
            @(negedge clk);
        end
    endtask

    task automatic test_simultaneous();
        bit seen;
        apply_reset();
        core_lat = 8'd0;
        a_in[7:0] = 8'd3;  b_in[7:0] = 8'd5;
        a_in[23:16] = 8'd7; b_in[23:16] = 8'd9;
        req = 4'b0101;
        wait_rsp(seen);
        checks++; if (!seen || rsp_valid !== 4'b0001) begin errors++; $display("FAIL simul1_first: got %b want 0001", rsp_valid); end
        checks++; if (rsp_product !== 16'd15) begin errors++; $display("FAIL simul1_first_product: got %0d want 15", rsp_product); end
        req = 4'b0100;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL simul_gap_idle: got %b want 0000", gnt); end
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL simul_next_gnt: got %b want 0100", gnt); end
        wait_rsp(seen);
        checks++; if (!seen || rsp_valid !== 4'b0100 || rsp_product !== 16'd63) begin errors++; $display("FAIL simul1_second: got %b/%0d want 0100/63", rsp_valid, rsp_product); end
        req = 4'b0000;
        @(negedge clk);
        a_in[7:0] = 8'd2;  b_in[7:0] = 8'd100;
        a_in[23:16] = 8'd12; b_in[23:16] = 8'd12;
        req = 4'b0101;
        wait_rsp(seen);
        checks++; if (!seen || rsp_valid !== 4'b0001 || rsp_product !== 16'd200) begin errors++; $display("FAIL simul2_wrap_first: got %b/%0d want 0001/200", rsp_valid, rsp_product); end
        req = 4'b0100;
        wait_rsp(seen);
        checks++; if (!seen || rsp_valid !== 4'b0100 || rsp_product !== 16'd144) begin errors++; $display("FAIL simul2_second: got %b/%0d want 0100/144", rsp_valid, rsp_product); end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit seen;
        logic [3:0]  oh_t [4];
        logic [15:0] p_t  [4];
        oh_t = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        p_t  = '{16'd30, 16'd100, 16'd210, 16'd360};
        apply_reset();
        core_lat = 8'd1;
        a_in = {8'd40, 8'd30, 8'd20, 8'd10};
        b_in = {8'd9, 8'd7, 8'd5, 8'd3};
        req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            wait_rsp(seen);
            checks++; if (!seen || rsp_valid !== oh_t[n % 4]) begin errors++; $display("FAIL b2b_order_%0d: got %b want %b", n, rsp_valid, oh_t[n % 4]); end
            checks++; if (rsp_product !== p_t[n % 4]) begin errors++; $display("FAIL b2b_product_%0d: got %0d want %0d", n, rsp_product, p_t[n % 4]); end
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit bad;
        core_lat = 8'd30;
        a_in[15:8] = 8'd9; b_in[15:8] = 8'd9;
        req = 4'b0010;
        repeat (5) @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL midrst_pre_gnt: got %b want 0010", gnt); end
        rst_n = 1'b0;
        req = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL midrst_async: got gnt=%b valid=%b want 0000/0000", gnt, rsp_valid); end
        checks++; if (mul_rst !== 1'b1 || mul_start !== 1'b0) begin errors++; $display("FAIL midrst_core_ctl: got rst=%b start=%b want 1/0", mul_rst, mul_start); end
        checks++; if ({mul_multiplier, mul_multiplicand} !== 16'd0) begin errors++; $display("FAIL midrst_operands: got %h want 0000", {mul_multiplier, mul_multiplicand}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL midrst_no_rsp: got a rsp_valid pulse want none"); end
        core_lat = 8'd1;
        a_in[23:16] = 8'd6; b_in[23:16] = 8'd7;
        req = 4'b0100;
        wait_rsp(seen);
        checks++; if (!seen || rsp_valid !== 4'b0100 || rsp_product !== 16'd42) begin errors++; $display("FAIL midrst_recover: got %b/%0d want 0100/42", rsp_valid, rsp_product); end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_spurious_done();
        bit bad;
        bad = 1'b0;
        @(negedge clk);
        done_spur = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000 || gnt !== 4'b0000) bad = 1'b1;
        end
        done_spur = 1'b0;
        @(negedge clk);
        checks++; if (bad || rsp_valid !== 4'b0000) begin errors++; $display("FAIL spurious_done: got valid=%b gnt=%b want idle", rsp_valid, gnt); end
    endtask

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        int cyc;
        apply_reset();
        core_hang = 1'b1;
        core_lat  = 8'd1;
        a_in[7:0] = 8'd5;  b_in[7:0] = 8'd5;
        a_in[15:8] = 8'd4; b_in[15:8] = 8'd4;
        req = 4'b0011;
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0000) begin
                cyc = k;
                break;
            end
        end
        checks++; if (cyc != 67) begin errors++; $display("FAIL timeout_cycle: got %0d want 67", cyc); end
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b1 || rsp_product !== 16'd0) begin errors++; $display("FAIL timeout_rsp: got %b err=%b p=%0d want 0001 err=1 p=0", rsp_valid, rsp_err, rsp_product); end
        req = 4'b0010;
        core_hang = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL timeout_next_gnt: got %b want 0010", gnt); end
        wait_rsp(seen);
        checks++; if (!seen || rsp_valid !== 4'b0010 || rsp_err !== 1'b0 || rsp_product !== 16'd16) begin errors++; $display("FAIL timeout_next_rsp: got %b err=%b p=%0d want 0010 err=0 p=16", rsp_valid, rsp_err, rsp_product); end
        req = 4'b0000;
        @(negedge clk);
    endtask
`endif

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        a_in      = '0;
        b_in      = '0;
        done_spur = 1'b0;
        core_hang = 1'b0;
        core_lat  = 8'd0;
        test_reset();
        test_single();
        test_corners();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_spurious_done();
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
